ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//   Registered RV32I(+M) control decoder with a valid/ready handshake. Sits between fetch and execute.
//   Decodes instr into datapath controls, flags illegal encodings, and holds back issue while the
//   non-pipelined mul/div unit is busy. Replaces the purely combinational control generator.
// PARAMETERS
//   EN_M    1   1: decode the M extension (func7=0000001 on opcode 01100); 0: those encodings are illegal
//   MD_LAT  32  cycles the mul/div unit stays busy after a M op issues; legal range 1..255
// PORTS
//   clk         in   1   clock
//   rst         in   1   asynchronous reset, active-high
//   flush       in   1   kill both buffered entries (branch redirect)
//   in_valid    in   1   instr is valid
//   in_ready    out  1   decoder accepts instr this cycle
//   instr       in   32  instruction word
//   out_valid   out  1   decoded controls are valid
//   out_ready   in   1   execute accepts the controls
//   ext_op      out  3   immediate type: 000 I, 001 U, 010 S, 011 B, 100 J
//   reg_w       out  1   register-file write enable
//   alu_src_a   out  1   0 rs1, 1 pc
//   alu_src_b   out  2   00 rs2, 01 imm, 10 const 4
//   alu_ctr     out  5   [4]=0: base ALU op {f7[5]|sltu,f3}; [4]=1: M op {2'b10,func3}
//   branch      out  3   000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 lt, 111 ge
//   mem_to_reg  out  1   writeback from load data
//   mem_w       out  1   store
//   mem_op      out  3   load/store func3
//   is_md       out  1   controls belong to a mul/div op
//   illegal     out  1   unsupported encoding; all side-effect controls forced to 0
//   md_busy     out  1   mul/div occupancy counter non-zero
// BEHAVIOUR
//   - Reset: every output 0 except in_ready=1; both entries empty; md counter 0.
//   - Decode table, base ops: lui, auipc, OP-IMM, OP, jal, jalr, branch, load, store.
//     Encodings are the same as the existing control generator. Exceptions:
//       sltu/sltiu/bltu/bgeu use alu_ctr 01010. Default for all controls is 0, so reg_w defaults to 0.
//   - Illegal conditions: instr[1:0]!=11; unlisted opcode; OP func7 not in {0000000,0100000}
//     (plus 0000001 when EN_M); branch func3 010/011; load func3 011/110/111; store func3 >010;
//     OP-IMM shifts with a bad func7. An illegal entry flows through the pipe with
//     reg_w=mem_w=mem_to_reg=0 and branch=000.
//   - Latency: 1 cycle from accept (in_valid&in_ready) to out_valid. Throughput is 1 per cycle.
//   - Buffering: 2-entry skid buffer (main + skid). in_ready is registered: in_ready = !skid_full.
//     The skid entry fills only when main is held (out_valid & !out_ready) and a new accept occurs.
//     Order is strictly FIFO.
//   - Issue = out_valid & out_ready. out_valid is masked (0) while md_busy and the head entry is_md.
//     Non-M entries issue freely while md_busy.
//   - md counter: loads MD_LAT on issue of an is_md entry; otherwise decrements to 0.
//     md_busy = (cnt!=0). Back-to-back M ops therefore issue MD_LAT+1 cycles apart.
//   - Flush: next cycle both entries are empty, out_valid=0, in_ready=1.
//     An accept in the flush cycle is dropped. The md counter is unaffected.
//     An issue in the flush cycle still counts.
//   - Simultaneous issue and accept with main full: main is refilled from skid, or from instr if
//     skid is empty. No bubble.
//   - Asynchronous reset mid-stream: all state is cleared immediately; outputs return to reset values.
//   - Controls are held stable while out_valid & !out_ready.
// STRUCTURE
//   - Shared package rv_ctrl_pkg: opcode constants (OPC_LUI..OPC_STORE), ext_op/branch/alu_src
//     codes, ALU_CTR_W=5, and the M-op prefix 2'b10.
//   - Sub-module ctrl_decode_comb: pure combinational instr -> control bundle + illegal + is_md,
//     parameterised by EN_M. Top level holds the skid buffer, the md counter and the issue masking.
// TESTING
//   1. Reset, then stream add,sub,lui,lw,sw with out_ready=1: each output appears 1 cycle after
//      accept; sub alu_ctr=01000; lw mem_to_reg=1, mem_op=010.
//   2. out_ready=0 for 3 cycles during a stream: in_ready drops after 2 accepts; no loss or
//      reorder on release.
//   3. EN_M=1, MD_LAT=4: mul followed by div: div out_valid masked, and div issues 5 cycles after mul.
//      An add queued behind mul issues at once.
//   4. EN_M=0 with a mul encoding, and instr=0x0000_0000: illegal=1, reg_w=0, mem_w=0, branch=000.
//   5. bltu -> branch=110, alu_ctr=01010; jal -> ext_op=100, branch=001, alu_src_b=10, reg_w=1.
//   6. flush with both entries full plus a concurrent in_valid: next cycle out_valid=0, in_ready=1,
//      nothing from the flush cycle is emitted. Repeat with rst asserted mid-burst.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_ctrl_pkg
//  Description : Shared RV32I(+M) control definitions: opcode constants,
//                immediate/branch/operand-select codes, ALU control codes
//                and the decoded control bundle carried down the pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam int ALU_CTR_W = 5;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // Immediate types
    localparam logic [2:0] c_ext_i = 3'b000;
    localparam logic [2:0] c_ext_u = 3'b001;
    localparam logic [2:0] c_ext_s = 3'b010;
    localparam logic [2:0] c_ext_b = 3'b011;
    localparam logic [2:0] c_ext_j = 3'b100;

    // Branch kinds
    localparam logic [2:0] c_br_none = 3'b000;
    localparam logic [2:0] c_br_jal  = 3'b001;
    localparam logic [2:0] c_br_jalr = 3'b010;
    localparam logic [2:0] c_br_beq  = 3'b100;
    localparam logic [2:0] c_br_bne  = 3'b101;
    localparam logic [2:0] c_br_lt   = 3'b110;
    localparam logic [2:0] c_br_ge   = 3'b111;

    // ALU operand selects
    localparam logic       c_src_a_rs1  = 1'b0;
    localparam logic       c_src_a_pc   = 1'b1;
    localparam logic [1:0] c_src_b_rs2  = 2'b00;
    localparam logic [1:0] c_src_b_imm  = 2'b01;
    localparam logic [1:0] c_src_b_four = 2'b10;

    // ALU controls that are not a plain {f7[5], func3}
    localparam logic [ALU_CTR_W-1:0] c_alu_add    = 5'b00000;
    localparam logic [ALU_CTR_W-1:0] c_alu_sub    = 5'b01000;
    localparam logic [ALU_CTR_W-1:0] c_alu_slt    = 5'b00010;
    localparam logic [ALU_CTR_W-1:0] c_alu_sltu   = 5'b01010;
    // 00011 is free because sltu moved to 01010; lui uses it to pass imm through
    localparam logic [ALU_CTR_W-1:0] c_alu_copy_b = 5'b00011;
    localparam logic [1:0]           c_md_prefix  = 2'b10;

    // func7 values on OP / shift-immediate
    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    typedef struct packed {
        logic [2:0]           ext_op;
        logic                 reg_w;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic [ALU_CTR_W-1:0] alu_ctr;
        logic [2:0]           branch;
        logic                 mem_to_reg;
        logic                 mem_w;
        logic [2:0]           mem_op;
        logic                 is_md;
        logic                 illegal;
    } ctrl_t;

    // Bundle presented for an unsupported encoding: nothing but the flag.
    function automatic ctrl_t ctrl_illegal();
        ctrl_t c;
        c         = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode_comb
//  Description : Purely combinational RV32I(+M) control decoder.
//                instr -> control bundle, including illegal and is_md flags.
//  Ports       : instr [31:0] in  - instruction word
//                ctrl  ctrl_t out - decoded controls
//  Parameters  : EN_M - non-zero enables decoding of the M extension
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_comb
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned EN_M = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [4:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_bad;
    ctrl_t      w_dec;
    logic       w_unused;

    assign w_opc = instr[6:2];
    assign w_f3  = instr[14:12];
    assign w_f7  = instr[31:25];

    // Register and immediate fields are not needed for control generation.
    assign w_unused = ^{instr[24:15], instr[11:7]};

    always_comb begin
        w_bad = 1'b0;
        w_dec = '0;
        if (instr[1:0] != 2'b11) begin
            w_bad = 1'b1;
        end else begin
            case (w_opc)
                OPC_LUI: begin
                    w_dec.ext_op    = c_ext_u;
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_b = c_src_b_imm;
                    w_dec.alu_ctr   = c_alu_copy_b;
                end
                OPC_AUIPC: begin
                    w_dec.ext_op    = c_ext_u;
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_a = c_src_a_pc;
                    w_dec.alu_src_b = c_src_b_imm;
                    w_dec.alu_ctr   = c_alu_add;
                end
                OPC_OP_IMM: begin
                    w_dec.ext_op    = c_ext_i;
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_b = c_src_b_imm;
                    w_dec.alu_ctr   = {2'b00, w_f3};
                    if (w_f3 == 3'b011) begin
                        w_dec.alu_ctr = c_alu_sltu;
                    end else if (w_f3 == 3'b101) begin
                        // srli/srai: f7[5] picks arithmetic shift
                        w_dec.alu_ctr[3] = w_f7[5];
                        w_bad = (w_f7 != c_f7_base) && (w_f7 != c_f7_alt);
                    end else if (w_f3 == 3'b001) begin
                        w_bad = (w_f7 != c_f7_base);
                    end
                end
                OPC_OP: begin
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_b = c_src_b_rs2;
                    if ((EN_M != 0) && (w_f7 == c_f7_muldiv)) begin
                        w_dec.is_md   = 1'b1;
                        w_dec.alu_ctr = {c_md_prefix, w_f3};
                    end else if ((w_f7 == c_f7_base) || (w_f7 == c_f7_alt)) begin
                        w_dec.alu_ctr = (w_f3 == 3'b011) ? c_alu_sltu
                                                         : {1'b0, w_f7[5], w_f3};
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                OPC_JAL: begin
                    w_dec.ext_op    = c_ext_j;
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_a = c_src_a_pc;
                    w_dec.alu_src_b = c_src_b_four;
                    w_dec.branch    = c_br_jal;
                end
                OPC_JALR: begin
                    w_dec.ext_op    = c_ext_i;
                    w_dec.reg_w     = 1'b1;
                    w_dec.alu_src_a = c_src_a_pc;
                    w_dec.alu_src_b = c_src_b_four;
                    w_dec.branch    = c_br_jalr;
                end
                OPC_BRANCH: begin
                    w_dec.ext_op    = c_ext_b;
                    w_dec.alu_src_b = c_src_b_rs2;
                    case (w_f3)
                        3'b000:  begin w_dec.branch = c_br_beq; w_dec.alu_ctr = c_alu_sub;  end
                        3'b001:  begin w_dec.branch = c_br_bne; w_dec.alu_ctr = c_alu_sub;  end
                        3'b100:  begin w_dec.branch = c_br_lt;  w_dec.alu_ctr = c_alu_slt;  end
                        3'b101:  begin w_dec.branch = c_br_ge;  w_dec.alu_ctr = c_alu_slt;  end
                        3'b110:  begin w_dec.branch = c_br_lt;  w_dec.alu_ctr = c_alu_sltu; end
                        3'b111:  begin w_dec.branch = c_br_ge;  w_dec.alu_ctr = c_alu_sltu; end
                        default: w_bad = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    w_dec.ext_op     = c_ext_i;
                    w_dec.reg_w      = 1'b1;
                    w_dec.alu_src_b  = c_src_b_imm;
                    w_dec.alu_ctr    = c_alu_add;
                    w_dec.mem_to_reg = 1'b1;
                    w_dec.mem_op     = w_f3;
                    w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
                end
                OPC_STORE: begin
                    w_dec.ext_op    = c_ext_s;
                    w_dec.alu_src_b = c_src_b_imm;
                    w_dec.alu_ctr   = c_alu_add;
                    w_dec.mem_w     = 1'b1;
                    w_dec.mem_op    = w_f3;
                    w_bad = w_f3[2] || (w_f3 == 3'b011);
                end
                default: w_bad = 1'b1;
            endcase
        end

        ctrl = w_dec;
        if (w_bad) begin
            ctrl = ctrl_illegal();
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode_pipe
//  Description : Registered RV32I(+M) control decoder between fetch and
//                execute. Two-entry skid buffer (main + skid) with
//                valid/ready on both sides, flush, and issue hold-off while
//                the non-pipelined mul/div unit is busy.
//  Ports       : clk, rst (async, active-high), flush
//                in_valid / in_ready / instr[31:0]      - fetch side
//                out_valid / out_ready                  - execute side
//                ext_op, reg_w, alu_src_a, alu_src_b, alu_ctr, branch,
//                mem_to_reg, mem_w, mem_op, is_md, illegal - decoded controls
//                md_busy                                - mul/div occupied
//  Parameters  : EN_M   - decode M extension when non-zero
//                MD_LAT - mul/div busy cycles after an M op issues (1..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned EN_M   = 1,
    parameter int unsigned MD_LAT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           ext_op,
    output logic                 reg_w,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_CTR_W-1:0] alu_ctr,
    output logic [2:0]           branch,
    output logic                 mem_to_reg,
    output logic                 mem_w,
    output logic [2:0]           mem_op,
    output logic                 is_md,
    output logic                 illegal,
    output logic                 md_busy
);

    localparam logic [7:0] c_md_lat = 8'(MD_LAT);

    ctrl_t      w_dec;
    ctrl_t      r_main;
    ctrl_t      r_skid;
    logic       r_main_valid;
    logic       r_skid_valid;
    logic [7:0] r_md_cnt;

    logic       w_accept;
    logic       w_md_busy;
    logic       w_out_valid;
    logic       w_issue;

    ctrl_decode_comb #(
        .EN_M (EN_M)
    ) u_decode (
        .instr (instr),
        .ctrl  (w_dec)
    );

    // in_ready comes straight from a flop: the skid slot is the only
    // thing that can refuse a new instruction.
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_md_busy   = (r_md_cnt != 8'd0);
    // An M op at the head waits for the mul/div unit; others pass freely.
    assign w_out_valid = r_main_valid & ~(w_md_busy & r_main.is_md);
    assign w_issue     = w_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Accept in this cycle is dropped along with both entries.
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_issue) begin
            // Main is free (or freeing): refill from skid first to keep order.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid       <= '0;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main       <= '0;
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is held; park the newcomer in the skid slot.
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    // Occupancy counter is independent of flush: an issued M op keeps the
    // unit busy even if the rest of the pipe is redirected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_cnt <= 8'd0;
        end else if (w_issue && r_main.is_md) begin
            r_md_cnt <= c_md_lat;
        end else if (r_md_cnt != 8'd0) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    assign in_ready   = ~r_skid_valid;
    assign out_valid  = w_out_valid;
    assign md_busy    = w_md_busy;
    assign ext_op     = r_main.ext_op;
    assign reg_w      = r_main.reg_w;
    assign alu_src_a  = r_main.alu_src_a;
    assign alu_src_b  = r_main.alu_src_b;
    assign alu_ctr    = r_main.alu_ctr;
    assign branch     = r_main.branch;
    assign mem_to_reg = r_main.mem_to_reg;
    assign mem_w      = r_main.mem_w;
    assign mem_op     = r_main.mem_op;
    assign is_md      = r_main.is_md;
    assign illegal    = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_decode_pipe
//  Description : Scoreboard bench for ctrl_decode_pipe. Two instances share
//                the stimulus: one with EN_M=1/MD_LAT=4, one with EN_M=0 and
//                the default latency. Expected bundles are queued on accept
//                and checked by a per-instance monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        ir_a, ov_a, busy_a, ir_b, ov_b, busy_b;
    logic [2:0]  ext_a, br_a, mop_a, ext_b, br_b, mop_b;
    logic        rw_a, sa_a, mr_a, mw_a, md_a, ill_a;
    logic        rw_b, sa_b, mr_b, mw_b, md_b, ill_b;
    logic [1:0]  sb_a, sb_b;
    logic [4:0]  alu_a, alu_b;
    logic [21:0] ctl_a, ctl_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.EN_M(1), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .instr(instr),
        .out_valid(ov_a), .out_ready(out_ready),
        .ext_op(ext_a), .reg_w(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
        .alu_ctr(alu_a), .branch(br_a), .mem_to_reg(mr_a), .mem_w(mw_a),
        .mem_op(mop_a), .is_md(md_a), .illegal(ill_a), .md_busy(busy_a)
    );

    ctrl_decode_pipe #(.EN_M(0)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .instr(instr),
        .out_valid(ov_b), .out_ready(out_ready),
        .ext_op(ext_b), .reg_w(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
        .alu_ctr(alu_b), .branch(br_b), .mem_to_reg(mr_b), .mem_w(mw_b),
        .mem_op(mop_b), .is_md(md_b), .illegal(ill_b), .md_busy(busy_b)
    );

    assign ctl_a = {ext_a, rw_a, sa_a, sb_a, alu_a, br_a, mr_a, mw_a, mop_a, md_a, ill_a};
    assign ctl_b = {ext_b, rw_b, sa_b, sb_b, alu_b, br_b, mr_b, mw_b, mop_b, md_b, ill_b};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    // Packing: {ext,reg_w,src_a,src_b,alu,branch,mem_to_reg,mem_w,mem_op,is_md,illegal}
    function automatic logic [21:0] ref_decode(input logic [31:0] ins, input bit en_m);
        logic [4:0] opc;
        logic [2:0] f3, ext, br, mop;
        logic [6:0] f7;
        logic [1:0] sb;
        logic [4:0] alu;
        logic       rw, sa, mr, mw, md, bad;
        opc = ins[6:2]; f3 = ins[14:12]; f7 = ins[31:25];
        ext = 0; br = 0; mop = 0; sb = 0; alu = 0;
        rw = 0; sa = 0; mr = 0; mw = 0; md = 0; bad = 0;
        if (ins[1:0] != 2'b11) bad = 1;
        else case (opc)
            5'b01101: begin ext = 1; rw = 1; sb = 1; alu = 5'd3; end              // lui
            5'b00101: begin ext = 1; rw = 1; sa = 1; sb = 1; end                  // auipc
            5'b00100: begin                                                        // op-imm
                rw = 1; sb = 1;
                case (f3)
                    3'd3:    alu = 5'd10;
                    3'd1:    begin alu = 5'd1; bad = (f7 != 0); end
                    3'd5:    begin alu = ins[30] ? 5'd13 : 5'd5; bad = !(f7 == 0 || f7 == 7'h20); end
                    default: alu = {2'b0, f3};
                endcase
            end
            5'b01100: begin                                                        // op
                rw = 1;
                if (en_m && f7 == 7'h01) begin md = 1; alu = 5'd16 + 5'(f3); end
                else if (f7 == 0 || f7 == 7'h20) alu = (f3 == 3) ? 5'd10 : (ins[30] ? 5'd8 : 5'd0) + 5'(f3);
                else bad = 1;
            end
            5'b11011: begin ext = 4; rw = 1; sa = 1; sb = 2; br = 1; end          // jal
            5'b11001: begin rw = 1; sa = 1; sb = 2; br = 2; end                   // jalr
            5'b11000: begin                                                        // branch
                ext = 3;
                case (f3)
                    3'd0: begin br = 4; alu = 5'd8;  end
                    3'd1: begin br = 5; alu = 5'd8;  end
                    3'd4: begin br = 6; alu = 5'd2;  end
                    3'd5: begin br = 7; alu = 5'd2;  end
                    3'd6: begin br = 6; alu = 5'd10; end
                    3'd7: begin br = 7; alu = 5'd10; end
                    default: bad = 1;
                endcase
            end
            5'b00000: begin rw = 1; sb = 1; mr = 1; mop = f3; bad = (f3 == 3 || f3 == 6 || f3 == 7); end
            5'b01000: begin ext = 2; sb = 1; mw = 1; mop = f3; bad = (f3 > 2); end
            default: bad = 1;
        endcase
        if (bad) return 22'd1;
        return {ext, rw, sa, sb, alu, br, mr, mw, mop, md, 1'b0};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] opc);
        return {f7, 5'd3, 5'd2, f3, 5'd1, opc, 2'b11};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [4:0]  opc;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0: opc = 5'b01101;  1: opc = 5'b00101;  2: opc = 5'b00100;
            3: opc = 5'b01100;  4: opc = 5'b11011;  5: opc = 5'b11001;
            6: opc = 5'b11000;  7: opc = 5'b00000;  8: opc = 5'b01000;
            9: opc = 5'b01100;  default: opc = w[6:2];
        endcase
        if (sel == 11) return w;
        w[6:2] = opc;
        w[1:0] = 2'b11;
        if (sel == 9) w[31:25] = 7'h01;
        else if (opc == 5'b01100 || opc == 5'b00100) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Per-instance scoreboard and cycle-level expectations.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam int LAT = (k == 0) ? 4 : 32;
        logic        m_ov, m_ir, m_busy;
        logic [21:0] m_ctl;
        logic [21:0] sbq[$];
        int          last_md = -1000;

        assign m_ov   = (k == 0) ? ov_a   : ov_b;
        assign m_ir   = (k == 0) ? ir_a   : ir_b;
        assign m_busy = (k == 0) ? busy_a : busy_b;
        assign m_ctl  = (k == 0) ? ctl_a  : ctl_b;

        always @(negedge clk) begin : p_mon
            int          cur;
            bit          e_busy, e_ov, e_ir;
            logic [21:0] head;
            cur = int'($time / 10);
            if (rst) begin
                sbq.delete();
                last_md = -1000;
                chk($sformatf("i%0d reset out_valid", k), 32'(m_ov), 32'd0);
                chk($sformatf("i%0d reset in_ready", k), 32'(m_ir), 32'd1);
                chk($sformatf("i%0d reset md_busy", k), 32'(m_busy), 32'd0);
                chk($sformatf("i%0d reset controls", k), 32'(m_ctl), 32'd0);
            end else begin
                head   = (sbq.size() > 0) ? sbq[0] : 22'd0;
                e_busy = (cur - last_md >= 1) && (cur - last_md <= LAT);
                e_ir   = (sbq.size() < 2);
                e_ov   = (sbq.size() > 0) && !(head[1] && e_busy);
                chk($sformatf("i%0d md_busy", k), 32'(m_busy), 32'(e_busy));
                chk($sformatf("i%0d in_ready", k), 32'(m_ir), 32'(e_ir));
                chk($sformatf("i%0d out_valid", k), 32'(m_ov), 32'(e_ov));
                if (e_ov) begin
                    chk($sformatf("i%0d controls", k), 32'(m_ctl), 32'(head));
                    if (out_ready) begin
                        if (head[1]) last_md = cur;
                        void'(sbq.pop_front());
                    end
                end
                if (flush) sbq.delete();
                else if (in_valid && e_ir) sbq.push_back(ref_decode(instr, k == 0));
            end
        end
    end

    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = iv;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until the EN_M=1 instance takes it.
    task automatic send(input logic [31:0] ins);
        bit acc;
        acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            in_valid = 1'b1;
            instr    = ins;
            flush    = 1'b0;
            acc      = ir_a;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic stream at full rate
        out_ready = 1'b1;
        send(mk(7'h00, 3'b000, 5'b01100));        // add
        send(mk(7'h20, 3'b000, 5'b01100));        // sub
        send(mk(7'h09, 3'b101, 5'b01101));        // lui
        send(mk(7'h00, 3'b010, 5'b00000));        // lw
        send(mk(7'h00, 3'b010, 5'b01000));        // sw
        idle(3);

        // Backpressure for 3 cycles during a stream
        for (int i = 0; i < 3; i++) step(1'b1, mk(7'h00, 3'(i), 5'b00100), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, mk(7'h00, 3'b111, 5'b01100), 1'b1, 1'b0);
        idle(3);

        // M-op hold-off: mul,add,div then mul,div
        send(mk(7'h01, 3'b000, 5'b01100));
        send(mk(7'h00, 3'b000, 5'b01100));
        send(mk(7'h01, 3'b100, 5'b01100));
        idle(8);
        send(mk(7'h01, 3'b000, 5'b01100));
        send(mk(7'h01, 3'b101, 5'b01100));
        idle(8);

        // Illegal encodings, then bltu and jal
        send(32'h0000_0000);
        send(mk(7'h01, 3'b011, 5'b01100));
        send(mk(7'h00, 3'b110, 5'b11000));        // bltu
        send(mk(7'h3f, 3'b000, 5'b11011));        // jal
        idle(8);

        // Flush with both entries full and a concurrent in_valid
        step(1'b1, mk(7'h00, 3'b000, 5'b01100), 1'b0, 1'b0);
        step(1'b1, mk(7'h20, 3'b000, 5'b01100), 1'b0, 1'b0);
        step(1'b1, mk(7'h00, 3'b010, 5'b00000), 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset mid-burst while the mul/div unit is busy
        send(mk(7'h01, 3'b000, 5'b01100));
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, mk(7'h00, 3'b000, 5'b01100), 1'b0, 1'b0);
        step(1'b1, mk(7'h20, 3'b000, 5'b01100), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(ov_a), 32'd0);
        chk("async rst in_ready", 32'(ir_a), 32'd1);
        chk("async rst md_busy", 32'(busy_a), 32'd0);
        chk("async rst controls", 32'(ctl_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 5) != 0, rnd_instr(), ($urandom % 4) != 0, ($urandom % 40) == 0);
        end
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
